nibble_serial_signed_adder: RTL
===============================

NIBBLE_SERIAL_SIGNED_ADDER -- requirements
Module: nibble_serial_signed_adder

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 up_valid  input  1  operand pair a/b presented.
REQ-005 up_ready  output  1  block can accept operands.
REQ-006 a  input  16  signed two's-complement operand A.
REQ-007 b  input  16  signed two's-complement operand B.
REQ-008 down_valid  output  1  result valid.
REQ-009 down_ready  input  1  consumer accepts result.
REQ-010 sum  output  16  a + b modulo 2^16.
REQ-011 overflow  output  1  signed result does not fit in 16 bits.
REQ-012 busy  output  1  high in CALC or DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-014 up_ready SHALL be 1 only in IDLE; down_valid SHALL be 1 only in DONE; busy SHALL equal (state != IDLE).
REQ-015 A transfer SHALL occur on a rising edge with up_valid && up_ready; a and b are then registered, carry cleared, nibble counter set to 0, and state goes IDLE -> CALC.
REQ-016 Without up_valid, IDLE SHALL hold; a/b changes outside a transfer SHALL have no effect.
REQ-017 Each CALC cycle SHALL add nibble k of A, nibble k of B and the stored carry with one 4-bit adder, writing the 4-bit result into sum[4k+3:4k] and the carry-out into the carry register.
REQ-018 The counter SHALL step 0,1,2,3; on the edge processing nibble 3 the state SHALL go CALC -> DONE.
REQ-019 Latency: down_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-020 In nibble 3, overflow SHALL be computed as carry into bit 15 XOR carry out of bit 15, and registered on that edge.
REQ-021 Carry out of bit 15 SHALL be discarded; sum wraps modulo 2^16.
REQ-022 In DONE, sum and overflow SHALL stay stable until a rising edge with down_ready=1, after which the state SHALL go DONE -> IDLE.
REQ-023 down_ready outside DONE SHALL be ignored; a new operand SHALL NOT be accepted in the cycle the result is consumed (up_ready is low in DONE).
REQ-024 sum and overflow SHALL retain the last result in IDLE until the next transfer; during CALC, sum bits above the current nibble are don't-care to the consumer.
REQ-025 Sustained throughput SHALL be one operation per 6 cycles with down_ready tied high.

Reset
REQ-026 Asserting rst SHALL, without waiting for clk, force state=IDLE, counter=0, carry=0, sum=16'h0000, overflow=0, down_valid=0, busy=0, up_ready=1.
REQ-027 Reset in CALC or DONE SHALL abandon the operation with no down_valid pulse; the first post-reset transfer SHALL produce a correct result.

Verification
REQ-028 a=16'h1234, b=16'h0FCD -> after 4 edges down_valid=1, sum=16'h2201, overflow=0.
REQ-029 a=16'h7FFF, b=16'h0001 -> sum=16'h8000, overflow=1; a=16'h8000, b=16'hFFFF -> sum=16'h7FFF, overflow=1.
REQ-030 a=16'hFFFF, b=16'h0001 -> sum=16'h0000, overflow=0 (carry out of bit 15 without overflow); a=16'h00FF, b=16'h0001 -> sum=16'h0100 (inter-nibble carry chain).
REQ-031 Backpressure: down_ready=0 for 10 cycles in DONE -> down_valid, sum and overflow held, up_ready=0, up_valid ignored; down_ready=1 -> IDLE next edge.
REQ-032 rst pulsed mid-edge in the 2nd CALC cycle -> outputs go to reset values immediately, no down_valid; next op a=16'h8000, b=16'h8000 -> sum=16'h0000, overflow=1.
REQ-033 Random signed operands, back-to-back with down_ready=1 -> every result matches a 17-bit signed reference model, one result per 6 cycles.

Source files
------------

// File: rtl/nibble_serial_signed_adder_if.sv
// nibble_serial_signed_adder_if: operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_signed_adder_if;
  logic up_valid;
  logic up_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic down_valid;
  logic down_ready;
  logic [15:0] sum;
  logic overflow;
  logic busy;
  modport master (
    output up_valid, a, b, down_ready,
    input up_ready, down_valid, sum, overflow, busy
  );
  modport slave (
    input up_valid, a, b, down_ready,
    output up_ready, down_valid, sum, overflow, busy
  );
endinterface

// File: rtl/nibble_serial_signed_adder.sv
// nibble_serial_signed_adder: 16-bit signed adder computed one nibble per cycle with valid/ready handshakes
module nibble_serial_signed_adder (
  input logic clk,
  input logic rst,
  nibble_serial_signed_adder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state, cnt;
  logic carry, ovf;
  logic [15:0] a_r, b_r, sum_r;
  logic [3:0] na, nb;
  logic [4:0] ns;
  logic cin3;
  always_comb begin
    na = a_r[{cnt, 2'b00} +: 4];
    nb = b_r[{cnt, 2'b00} +: 4];
    ns = {1'b0, na} + {1'b0, nb} + {4'b0000, carry};
    cin3 = ns[3] ^ na[3] ^ nb[3];
  end
  // carry into the top bit is recovered from the nibble's MSB sum bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      carry <= 1'b0;
      ovf <= 1'b0;
      a_r <= 16'h0000;
      b_r <= 16'h0000;
      sum_r <= 16'h0000;
    end else
      case (state)
        IDLE: if (bus.up_valid) begin
          a_r <= bus.a;
          b_r <= bus.b;
          carry <= 1'b0;
          cnt <= 2'd0;
          state <= CALC;
        end
        CALC: begin
          sum_r[{cnt, 2'b00} +: 4] <= ns[3:0];
          carry <= ns[4];
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            ovf <= cin3 ^ ns[4];
            state <= DONE;
          end
        end
        DONE: if (bus.down_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
  assign bus.up_ready = state == IDLE;
  assign bus.down_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.sum = sum_r;
  assign bus.overflow = ovf;
endmodule
